id_issue_queue: RTL and testbench

- Parametrised successor to the single-entry ID/EX pipeline register. It is a DEPTH-entry in-order queue between the decoder and the EX stage.
- Decouples decode from execute: EX stalls no longer have to freeze decode immediately.
- Each entry holds the decoded payload, PC, destination register and write/load flags.
- A scoreboard compares queued load destinations against the decoder's source register addresses and drives the load-hazard interlock.

---
 rtl/id_issue_queue_if.sv | 45 ++++
 rtl/id_issue_queue.sv | 98 +++++++++
 tb/tb_id_issue_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/id_issue_queue_if.sv
// Decoder/EX-side bundle for the in-order issue queue between ID and EX.
// Push handshake: a push happens on a rising edge where in_en_=0, in_ready=1 and flush=0.
// Pop handshake: the head (out_en_=0) leaves on a rising edge where stall=0 and flush=0.
interface id_issue_queue_if #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 96,
    parameter int PC_W      = 30,
    parameter int REG_AW    = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 in_en_;
    logic [PC_W-1:0]      in_pc;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [REG_AW-1:0]    in_dst_addr;
    logic                 in_gpr_we_;
    logic                 in_is_ld;
    logic                 in_ready;
    logic [REG_AW-1:0]    rs_addr_0;
    logic [REG_AW-1:0]    rs_addr_1;
    logic                 ld_hazard;
    logic                 stall;
    logic                 flush;
    logic                 out_en_;
    logic [PC_W-1:0]      out_pc;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [REG_AW-1:0]    out_dst_addr;
    logic                 out_gpr_we_;
    logic                 out_is_ld;
    logic [CNT_W-1:0]     count;

    modport master (
        output in_en_, in_pc, in_payload, in_dst_addr, in_gpr_we_, in_is_ld,
               rs_addr_0, rs_addr_1, stall, flush,
        input  in_ready, ld_hazard, out_en_, out_pc, out_payload, out_dst_addr,
               out_gpr_we_, out_is_ld, count
    );

    modport slave (
        input  in_en_, in_pc, in_payload, in_dst_addr, in_gpr_we_, in_is_ld,
               rs_addr_0, rs_addr_1, stall, flush,
        output in_ready, ld_hazard, out_en_, out_pc, out_payload, out_dst_addr,
               out_gpr_we_, out_is_ld, count
    );
endinterface

// File: rtl/id_issue_queue.sv
// DEPTH-entry in-order issue queue between decode and EX, with a load-use
// scoreboard over the queued load destinations.
module id_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 96,
    parameter int PC_W      = 30,
    parameter int REG_AW    = 5
) (
    input  logic clk,
    input  logic reset_,
    id_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]      r_pc      [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [REG_AW-1:0]    r_dst     [DEPTH];
    logic [DEPTH-1:0]     r_we_;
    logic [DEPTH-1:0]     r_ld;
    logic [DEPTH-1:0]     r_vld;
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_rp;
    logic [CW-1:0]        r_count;

    logic w_empty;
    logic w_in_ready;
    logic w_push;
    logic w_pop;
    logic w_hazard;

    // in_ready depends on registered occupancy only, never on stall.
    assign w_empty    = (r_count == '0);
    assign w_in_ready = (r_count != CW'(DEPTH));
    assign w_push     = ~bus.in_en_ & w_in_ready & ~bus.flush;
    assign w_pop      = ~w_empty & ~bus.stall & ~bus.flush;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else if (bus.flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            // Push and pop never target the same slot: that needs count 0 or DEPTH.
            if (w_pop) begin
                r_rp        <= r_rp + 1'b1;
                r_vld[r_rp] <= 1'b0;
            end
            if (w_push) begin
                r_wp        <= r_wp + 1'b1;
                r_vld[r_wp] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry data needs no reset; it is only observed through a valid bit or non-empty head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wp]      <= bus.in_pc;
            r_payload[r_wp] <= bus.in_payload;
            r_dst[r_wp]     <= bus.in_dst_addr;
            r_we_[r_wp]     <= bus.in_gpr_we_;
            r_ld[r_wp]      <= bus.in_is_ld;
        end
    end

    // The popping entry still counts; the incoming entry does not.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && r_ld[i] && !r_we_[i] &&
                ((r_dst[i] == bus.rs_addr_0) || (r_dst[i] == bus.rs_addr_1))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.ld_hazard    = w_hazard;
    assign bus.count        = r_count;
    assign bus.out_en_      = w_empty;
    assign bus.out_pc       = w_empty ? '0   : r_pc[r_rp];
    assign bus.out_payload  = w_empty ? '0   : r_payload[r_rp];
    assign bus.out_dst_addr = w_empty ? '0   : r_dst[r_rp];
    assign bus.out_gpr_we_  = w_empty ? 1'b1 : r_we_[r_rp];
    assign bus.out_is_ld    = w_empty ? 1'b0 : r_ld[r_rp];
endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model of the issue queue.
module tb_id_issue_queue;
  localparam int DEPTH     = 4;
  localparam int PAYLOAD_W = 96;
  localparam int PC_W      = 30;
  localparam int REG_AW    = 5;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int EW        = PC_W + PAYLOAD_W + REG_AW + 2;
  localparam int DST_LSB   = 2;
  localparam int PL_LSB    = DST_LSB + REG_AW;
  localparam int PC_LSB    = PL_LSB + PAYLOAD_W;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  id_issue_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .PC_W(PC_W), .REG_AW(REG_AW)) bus ();

  id_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .PC_W(PC_W), .REG_AW(REG_AW)) dut (
    .clk(clk),
    .reset_(reset_),
    .bus(bus)
  );

  // model entry layout: {pc, payload, dst, gpr_we_, is_ld}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [EW-1:0] h;
    logic [EW-1:0] e;
    logic hz;
    logic emp;
    emp = (exp_q.size() == 0);
    h = '0;
    h[1] = 1'b1;
    if (!emp) h = exp_q[0];
    hz = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (e[0] && !e[1] &&
          (e[DST_LSB +: REG_AW] == bus.rs_addr_0 || e[DST_LSB +: REG_AW] == bus.rs_addr_1))
        hz = 1'b1;
    end
    chk({ph, ".out_en_"}, 128'(bus.out_en_), 128'(emp));
    chk({ph, ".count"}, 128'(bus.count), 128'(exp_q.size()));
    chk({ph, ".in_ready"}, 128'(bus.in_ready), 128'(exp_q.size() != DEPTH));
    chk({ph, ".ld_hazard"}, 128'(bus.ld_hazard), 128'(hz));
    chk({ph, ".out_pc"}, 128'(bus.out_pc), 128'(h[PC_LSB +: PC_W]));
    chk({ph, ".out_payload"}, 128'(bus.out_payload), 128'(h[PL_LSB +: PAYLOAD_W]));
    chk({ph, ".out_dst"}, 128'(bus.out_dst_addr), 128'(h[DST_LSB +: REG_AW]));
    chk({ph, ".out_gpr_we_"}, 128'(bus.out_gpr_we_), 128'(h[1]));
    chk({ph, ".out_is_ld"}, 128'(bus.out_is_ld), 128'(h[0]));
  endtask

  task automatic drive(input logic en_, input logic [PC_W-1:0] pc, input logic [REG_AW-1:0] dst,
                       input logic we_, input logic ld, input logic stall, input logic flush,
                       input logic [REG_AW-1:0] rs0, input logic [REG_AW-1:0] rs1);
    bus.in_en_      = en_;
    bus.in_pc       = pc;
    bus.in_payload  = {$urandom, $urandom, $urandom};
    bus.in_dst_addr = dst;
    bus.in_gpr_we_  = we_;
    bus.in_is_ld    = ld;
    bus.stall       = stall;
    bus.flush       = flush;
    bus.rs_addr_0   = rs0;
    bus.rs_addr_1   = rs1;
  endtask

  task automatic idle(input logic stall);
    drive(1'b1, '0, '0, 1'b1, 1'b0, stall, 1'b0, '0, '0);
  endtask

  // Called at a falling edge with inputs applied; checks, clocks, updates model.
  task automatic step(input string ph);
    logic push;
    logic pop;
    logic fl;
    logic [EW-1:0] e;
    #1;
    check_outputs(ph);
    fl   = bus.flush;
    push = !bus.in_en_ && (exp_q.size() != DEPTH) && !fl;
    pop  = (exp_q.size() != 0) && !bus.stall && !fl;
    e = {bus.in_pc, bus.in_payload, bus.in_dst_addr, bus.in_gpr_we_, bus.in_is_ld};
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    reset_ = 1'b0;
    idle(1'b0);
    #2;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_ = 1'b1;

    for (int i = 0; i < 10; i++) step("idle");

    // pass-through
    drive(1'b0, 30'h10, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step("pt_push");
    idle(1'b0);
    chk("pt_head_pc", 128'(bus.out_pc), 128'h10);
    chk("pt_head_en", 128'(bus.out_en_), 128'h0);
    step("pt_pop");
    chk("pt_empty", 128'(bus.out_en_), 128'h1);

    // fill with stall, fifth push ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 30'(32'h20 + i), 5'(i), 1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
      step("fill");
    end
    chk("fill_count", 128'(bus.count), 128'd4);
    chk("fill_ready", 128'(bus.in_ready), 128'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("fill_head", 128'(bus.out_pc), 128'(32'h20 + i));
      step("drain");
    end
    chk("drain_empty", 128'(bus.out_en_), 128'h1);

    // continuous push/pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 30'(32'h30 + i), 5'(i), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      step("wrap");
      chk("wrap_count", 128'(bus.count), 128'd1);
      chk("wrap_head", 128'(bus.out_pc), 128'(32'h30 + i));
    end
    idle(1'b0);
    step("wrap_tail");

    // load hazard
    drive(1'b0, 30'h40, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    step("ld_push");
    drive(1'b1, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 5'd7);
    #1 chk("ld_hazard_on", 128'(bus.ld_hazard), 128'd1);
    step("ld_hold");
    drive(1'b1, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 5'd7);
    #1 chk("ld_hazard_popping", 128'(bus.ld_hazard), 128'd1);
    step("ld_pop");
    chk("ld_hazard_off", 128'(bus.ld_hazard), 128'd0);
    drive(1'b0, 30'h41, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd7);
    step("nold_push");
    drive(1'b0, 30'h42, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 5'd7);
    step("nowe_push");
    drive(1'b1, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd7);
    #1 chk("ld_hazard_nonld", 128'(bus.ld_hazard), 128'd0);
    step("nold_hold");
    drive(1'b1, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1, '0, '0);
    step("flush_clear");

    // flush priority over push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 30'(32'h60 + i), 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
      step("fl_fill");
    end
    chk("fl_count3", 128'(bus.count), 128'd3);
    drive(1'b0, 30'h99, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd1);
    step("fl_assert");
    chk("fl_count0", 128'(bus.count), 128'd0);
    chk("fl_out_en", 128'(bus.out_en_), 128'd1);
    drive(1'b0, 30'h50, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step("fl_push");
    chk("fl_next_pc", 128'(bus.out_pc), 128'h50);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 2) == 0), 30'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step("rand");
    end

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 30'(32'h70 + i), 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, '0);
      step("rst_fill");
    end
    idle(1'b1);
    #2 reset_ = 1'b0;
    exp_q.delete();
    #1 check_outputs("rst_async");
    @(negedge clk);
    reset_ = 1'b1;
    step("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
